// File: rtl/qoi_pkg.sv
// qoi_pkg
// Shared definitions for the QOI capture/encode path: scheduler state
// encoding, pixel width and default frame geometry used by the scheduler,
// the encoder and the line buffer.
package qoi_pkg;

  // Width of one RGB444 pixel.
  localparam int RGB444_W = 12;

  // Default frame geometry.
  localparam int QOI_H_PIXELS = 640;
  localparam int QOI_V_LINES  = 480;

  typedef enum logic [2:0] {
    IDLE,
    ENC_RST,
    WAIT_LINE,
    FEED,
    LINE_END,
    FLUSH
  } sched_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qoi_frame_sched_if.sv
// qoi_frame_sched_if
// Bundles the line-buffer read port and the encoder control port driven by
// the frame scheduler.
//   line buffer : line_valid (to sched), line_done, pix_rd, pix_addr (from
//                 sched), pix_data (to sched, valid the cycle after pix_rd)
//   encoder     : enc_rgb, enc_en, enc_rst_n, eof_req (from sched),
//                 out_afull (to sched, compressed-stream FIFO almost full)
// Modports: master = scheduler side, slave = line buffer / encoder side.
interface qoi_frame_sched_if #(
  parameter int ADDR_W = 10
);
  import qoi_pkg::*;

  logic                line_valid;
  logic                line_done;
  logic                pix_rd;
  logic [ADDR_W-1:0]   pix_addr;
  logic [RGB444_W-1:0] pix_data;
  logic [RGB444_W-1:0] enc_rgb;
  logic                enc_en;
  logic                enc_rst_n;
  logic                out_afull;
  logic                eof_req;

  modport master (
    input  line_valid, pix_data, out_afull,
    output line_done, pix_rd, pix_addr, enc_rgb, enc_en, enc_rst_n, eof_req
  );

  modport slave (
    output line_valid, pix_data, out_afull,
    input  line_done, pix_rd, pix_addr, enc_rgb, enc_en, enc_rst_n, eof_req
  );

endinterface

// File: rtl/qoi_pix_pacer.sv
// qoi_pix_pacer
// Reads one line out of the line buffer at a fixed cadence and forwards each
// pixel to the encoder.
//   clk, rst   : clock, synchronous active-high reset
//   run        : high while the scheduler is in FEED; low clears the counters
//   out_afull  : downstream FIFO almost full, sampled at phase 0 only
//   pix_data   : line-buffer read data (valid the cycle after pix_rd)
//   pix_rd     : line-buffer read strobe
//   pix_addr   : read address (current pixel index)
//   enc_rgb    : pixel to encoder, held between enc_en pulses
//   enc_en     : one-cycle encoder enable, two cycles after pix_rd
//   line_last  : coincides with the enc_en of the last pixel of the line
module qoi_pix_pacer
  import qoi_pkg::*;
#(
  parameter  int H_PIXELS   = QOI_H_PIXELS,
  parameter  int PIX_PERIOD = 2,
  localparam int ADDR_W     = $clog2(H_PIXELS),
  localparam int PH_W       = cnt_w(PIX_PERIOD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                out_afull,
  input  logic [RGB444_W-1:0] pix_data,
  output logic                pix_rd,
  output logic [ADDR_W-1:0]   pix_addr,
  output logic [RGB444_W-1:0] enc_rgb,
  output logic                enc_en,
  output logic                line_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_PIXELS - 1);
  localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(PIX_PERIOD - 1);

  logic [PH_W-1:0]     phase_reg, phase_next;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic                all_read_reg, all_read_next;
  logic                is_last_idx;

  // Read -> data -> encoder pipeline.
  logic                rd_d1_reg;
  logic                last_d1_reg;
  logic                enc_en_reg;
  logic                line_last_reg;
  logic [RGB444_W-1:0] enc_rgb_reg;

  always_comb begin
    is_last_idx   = (idx_reg == LAST_IDX);
    // A read is only launched at phase 0; once launched the phase runs on
    // regardless of out_afull, so an issued pixel always completes.
    pix_rd        = run && (phase_reg == '0) && !out_afull && !all_read_reg;
    phase_next    = phase_reg;
    idx_next      = idx_reg;
    all_read_next = all_read_reg;

    if (!run) begin
      phase_next    = '0;
      idx_next      = '0;
      all_read_next = 1'b0;
    end else if (pix_rd) begin
      phase_next = PH_W'(1);
      // Index stops at the last pixel instead of wrapping; the flag
      // blocks further reads until the next line.
      if (is_last_idx) begin
        all_read_next = 1'b1;
      end else begin
        idx_next = idx_reg + ADDR_W'(1);
      end
    end else if (phase_reg != '0) begin
      phase_next = (phase_reg == LAST_PH) ? '0 : phase_reg + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg     <= '0;
      idx_reg       <= '0;
      all_read_reg  <= 1'b0;
      rd_d1_reg     <= 1'b0;
      last_d1_reg   <= 1'b0;
      enc_en_reg    <= 1'b0;
      line_last_reg <= 1'b0;
      enc_rgb_reg   <= '0;
    end else begin
      phase_reg     <= phase_next;
      idx_reg       <= idx_next;
      all_read_reg  <= all_read_next;
      rd_d1_reg     <= pix_rd;
      last_d1_reg   <= pix_rd && is_last_idx;
      enc_en_reg    <= rd_d1_reg;
      line_last_reg <= last_d1_reg;
      if (rd_d1_reg) begin
        enc_rgb_reg <= pix_data;
      end
    end
  end

  assign pix_addr  = idx_reg;
  assign enc_rgb   = enc_rgb_reg;
  assign enc_en    = enc_en_reg;
  assign line_last = line_last_reg;

endmodule

// File: rtl/qoi_frame_sched.sv
// qoi_frame_sched
// Frame-level controller that walks the QOI RGB444 encoder through a camera
// frame: encoder reset pulse, line-by-line feeding from the line buffer,
// then an end-of-stream request.
//   clk, rst     : clock, synchronous active-high reset
//   frame_start  : one-cycle start pulse, accepted only in IDLE
//   busy         : high in every state except IDLE
//   line_cnt     : index of the line being encoded
//   frame_cnt    : completed frames, wraps modulo 2^16
//   overrun      : sticky, frame_start seen while busy (cleared by rst only)
//   bus          : line-buffer and encoder signals (master side)
// Parameters: PIX_PERIOD >= 2, ENC_RST_CYCLES >= 1, FLUSH_CYCLES >= 1,
// and the interface ADDR_W must equal $clog2(H_PIXELS).
module qoi_frame_sched
  import qoi_pkg::*;
#(
  parameter int H_PIXELS       = QOI_H_PIXELS,
  parameter int V_LINES        = QOI_V_LINES,
  parameter int PIX_PERIOD     = 2,
  parameter int ENC_RST_CYCLES = 2,
  parameter int FLUSH_CYCLES   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  output logic                         busy,
  output logic [$clog2(V_LINES)-1:0]   line_cnt,
  output logic [15:0]                  frame_cnt,
  output logic                         overrun,
  qoi_frame_sched_if.master            bus
);

  localparam int ADDR_W  = $clog2(H_PIXELS);
  localparam int LC_W    = $clog2(V_LINES);
  localparam int TMR_MAX = (ENC_RST_CYCLES > FLUSH_CYCLES) ? ENC_RST_CYCLES : FLUSH_CYCLES;
  localparam int TMR_W   = cnt_w(TMR_MAX);

  localparam logic [LC_W-1:0]  LAST_LINE   = LC_W'(V_LINES - 1);
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(ENC_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] FLUSH_LAST  = TMR_W'(FLUSH_CYCLES - 1);

  sched_state_t        state_reg, state_next;
  logic [TMR_W-1:0]    tmr_reg, tmr_next;
  logic [LC_W-1:0]     line_cnt_reg, line_cnt_next;
  logic [15:0]         frame_cnt_reg, frame_cnt_next;
  logic                overrun_reg, overrun_next;
  logic                enc_rst_n_reg;

  logic                feed_run;
  logic                line_done;
  logic                eof_req;

  logic                pix_rd;
  logic [ADDR_W-1:0]   pix_addr;
  logic [RGB444_W-1:0] enc_rgb;
  logic                enc_en;
  logic                line_last;

  qoi_pix_pacer #(
    .H_PIXELS   (H_PIXELS),
    .PIX_PERIOD (PIX_PERIOD)
  ) u_pacer (
    .clk       (clk),
    .rst       (rst),
    .run       (feed_run),
    .out_afull (bus.out_afull),
    .pix_data  (bus.pix_data),
    .pix_rd    (pix_rd),
    .pix_addr  (pix_addr),
    .enc_rgb   (enc_rgb),
    .enc_en    (enc_en),
    .line_last (line_last)
  );

  always_comb begin
    state_next     = state_reg;
    tmr_next       = '0;
    line_cnt_next  = line_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    feed_run       = 1'b0;
    line_done      = 1'b0;
    eof_req        = 1'b0;
    overrun_next   = overrun_reg | (frame_start && (state_reg != IDLE));

    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next    = ENC_RST;
          line_cnt_next = '0;
        end
      end
      ENC_RST: begin
        if (tmr_reg == RST_LAST) begin
          state_next = WAIT_LINE;
        end else begin
          tmr_next = tmr_reg + TMR_W'(1);
        end
      end
      WAIT_LINE: begin
        // Pacer is held cleared here (feed_run low), so each line starts
        // at pixel 0, phase 0.
        if (bus.line_valid) begin
          state_next = FEED;
        end
      end
      FEED: begin
        // line_valid is not looked at: the buffer keeps the line until
        // line_done.
        feed_run = 1'b1;
        if (line_last) begin
          state_next = LINE_END;
        end
      end
      LINE_END: begin
        line_done = 1'b1;
        if (line_cnt_reg == LAST_LINE) begin
          state_next = FLUSH;
        end else begin
          line_cnt_next = line_cnt_reg + LC_W'(1);
          state_next    = WAIT_LINE;
        end
      end
      FLUSH: begin
        // LINE_END plus FLUSH_CYCLES-1 quiet FLUSH cycles give FLUSH_CYCLES
        // idle cycles after the last enc_en; eof_req lands in the next one,
        // FLUSH_CYCLES cycles after line_done.
        if (tmr_reg == FLUSH_LAST) begin
          eof_req        = 1'b1;
          frame_cnt_next = frame_cnt_reg + 16'd1;
          state_next     = IDLE;
        end else begin
          tmr_next = tmr_reg + TMR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      tmr_reg       <= '0;
      line_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      overrun_reg   <= 1'b0;
      enc_rst_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmr_reg       <= tmr_next;
      line_cnt_reg  <= line_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      overrun_reg   <= overrun_next;
      // Registered so the encoder stays in reset while rst is high and is
      // released one cycle after rst falls; low exactly during ENC_RST.
      enc_rst_n_reg <= (state_next != ENC_RST);
    end
  end

  assign busy          = (state_reg != IDLE);
  assign line_cnt      = line_cnt_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign overrun       = overrun_reg;

  assign bus.line_done = line_done;
  assign bus.pix_rd    = pix_rd;
  assign bus.pix_addr  = pix_addr;
  assign bus.enc_rgb   = enc_rgb;
  assign bus.enc_en    = enc_en;
  assign bus.enc_rst_n = enc_rst_n_reg;
  assign bus.eof_req   = eof_req;

endmodule

// File: doc/qoi_frame_sched.md
Name: qoi_frame_sched

Overview:
- Frame-level controller that sequences qoi_rgb444_encoder across a full camera frame.
- On frame start it pulses the encoder reset, then waits for each captured line in the line buffer and reads it pixel by pixel.
- Each pixel is presented to the encoder with a one-cycle enable at a fixed cadence, with back-pressure from the compressed-stream FIFO.
- After the last line it requests the QOI end marker and returns to idle.

Parameters:
- H_PIXELS, 640, pixels per line; pix_addr width is $clog2(H_PIXELS).
- V_LINES, 480, lines per frame.
- PIX_PERIOD, 2, clock cycles per encoded pixel; must be >= 2.
- ENC_RST_CYCLES, 2, cycles enc_rst_n is held low at frame start.
- FLUSH_CYCLES, 8, idle cycles after the last pixel before eof_req.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse from the capture block (VSYNC-derived).
- line_valid  in  1  line buffer holds a complete line ready for reading.
- line_done  out  1  one-cycle pulse; releases the current line buffer.
- pix_rd  out  1  line-buffer read strobe.
- pix_addr  out  $clog2(H_PIXELS)  read address.
- pix_data  in  12  RGB444 read data, valid the cycle after pix_rd.
- enc_rgb  out  12  pixel to encoder; held stable between enc_en pulses.
- enc_en  out  1  encoder enable, one cycle per pixel.
- enc_rst_n  out  1  encoder reset, active-low.
- out_afull  in  1  compressed-stream FIFO almost full.
- eof_req  out  1  one-cycle pulse; encoder/packer appends the QOI end marker.
- busy  out  1  high in every state except IDLE.
- line_cnt  out  $clog2(V_LINES)  index of the line being encoded.
- frame_cnt  out  16  completed frames; wraps at 65535 to 0.
- overrun  out  1  sticky; frame_start arrived while busy.

Behaviour:
- Reset values (while rst is high):
  - all outputs 0, including enc_rst_n = 0 (encoder held in reset), overrun and frame_cnt.
  - state = IDLE.
  - enc_rst_n rises in the first cycle after rst falls.
- States: IDLE, ENC_RST, WAIT_LINE, FEED, LINE_END, FLUSH.
- IDLE:
  - frame_start moves to ENC_RST next cycle; line_cnt <= 0.
- ENC_RST:
  - enc_rst_n = 0 for exactly ENC_RST_CYCLES cycles, then WAIT_LINE.
- WAIT_LINE:
  - line_valid high moves to FEED.
  - Pixel index and pacing phase clear to 0.
- FEED (pacing phase counts 0..PIX_PERIOD-1):
  - Phase 0 with out_afull low: pix_rd = 1, pix_addr = pixel index; phase advances.
  - Phase 0 with out_afull high: no read; phase holds at 0 (stall).
  - out_afull is sampled only at phase 0. A pixel already read always completes.
  - Pixel read in cycle t: enc_rgb <= pix_data and enc_en = 1 in cycle t+2 (registered).
  - Unstalled throughput is exactly one enc_en per PIX_PERIOD cycles.
  - After the enc_en of pixel H_PIXELS-1, go to LINE_END.
- LINE_END:
  - line_done = 1 for one cycle.
  - If line_cnt == V_LINES-1, go to FLUSH; otherwise line_cnt++ and go to WAIT_LINE.
- FLUSH:
  - Wait FLUSH_CYCLES cycles, then eof_req = 1 for one cycle.
  - In the same cycle: frame_cnt++ and go to IDLE.
- frame_start while busy:
  - Ignored; the current frame completes.
  - overrun <= 1, cleared only by rst.
- frame_start in the same cycle the FSM enters IDLE is not accepted; it must arrive while IDLE.
- line_valid dropping mid-FEED is ignored; the line buffer holds data until line_done.
- rst mid-frame:
  - Abort next cycle to IDLE with all outputs at reset values.
  - No line_done and no eof_req are emitted.
- enc_en is never high while enc_rst_n is low.

Decomposition:
- Package qoi_pkg holds:
  - sched_state_t enum (IDLE, ENC_RST, WAIT_LINE, FEED, LINE_END, FLUSH).
  - RGB444_W = 12.
  - Default H_PIXELS and V_LINES constants shared with the encoder and line buffer.
- Sub-module qoi_pix_pacer contains:
  - the phase counter, pixel index counter and out_afull stall logic.
  - the 2-stage pix_rd -> enc_en pipeline.
  - outputs pix_rd, pix_addr, enc_en and a line_last pulse.
- The FSM lives in qoi_frame_sched.

Test Plan:
(Parameters H_PIXELS=4, V_LINES=2, PIX_PERIOD=2, ENC_RST_CYCLES=2, FLUSH_CYCLES=8 unless noted.)
- Reset: hold rst 3 cycles -> all outputs 0 and enc_rst_n = 0; enc_rst_n = 1 in the first cycle after release; busy = 0.
- Nominal frame: frame_start pulse, line_valid tied high ->
  - enc_rst_n low 2 cycles.
  - pix_addr 0,1,2,3 on alternating cycles; enc_en 2 cycles after each pix_rd with enc_rgb equal to the driven data (e.g. 12'hFFF, 12'h0F0).
  - two line_done pulses, eof_req 8 cycles after the final line_done, frame_cnt = 1.
- Back-pressure: assert out_afull for 6 cycles after pixel 1's read ->
  - pixel 1 still reaches enc_en.
  - no pix_rd while out_afull is high.
  - pixel 2 read in the first phase-0 cycle after out_afull falls.
  - total enc_en count per line = 4.
- Line starvation: line_valid low for 20 cycles before line 1 -> FSM waits in WAIT_LINE, no pix_rd or enc_en, line_cnt = 1; resumes when line_valid rises.
- Overrun and abort:
  - frame_start during FEED -> overrun = 1, frame completes normally.
  - Separately, rst mid-line -> next cycle IDLE, no eof_req, frame_cnt unchanged.
- Cadence: PIX_PERIOD=3 -> enc_en spacing exactly 3 cycles.
